// File: rtl/rvfi_sched_pkg.sv
// Shared types, default parameters and elaboration-time parameter validation
// for rvfi_check_scheduler.
package rvfi_sched_pkg;

    typedef enum logic [2:0] {
        RST,
        ARM,
        WAIT,
        DONE,
        ABORT
    } sched_state_e;

    localparam int unsigned DEF_NRET         = 1;
    localparam int unsigned DEF_CHANNEL_IDX  = 0;
    localparam int unsigned DEF_RESET_CYCLES = 1;
    localparam int unsigned DEF_TRIG_MIN     = 4;
    localparam int unsigned DEF_TRIG_MAX     = 20;
    localparam int unsigned DEF_CHECK_DELAY  = 10;
    localparam int unsigned DEF_CNT_W        = 16;

    // Widths above 32 are rejected so the all-ones bound fits 64-bit math.
    function automatic bit sched_params_ok(
        input int unsigned nret,
        input int unsigned channel_idx,
        input int unsigned reset_cycles,
        input int unsigned trig_min,
        input int unsigned trig_max,
        input int unsigned check_delay,
        input int unsigned cnt_w
    );
        longint unsigned cmax;
        longint unsigned rc;
        longint unsigned tmin;
        longint unsigned tmax;
        longint unsigned dly;
        if (cnt_w < 1 || cnt_w > 32) return 1'b0;
        cmax = (64'd1 << cnt_w) - 64'd1;
        rc   = 64'(reset_cycles);
        tmin = 64'(trig_min);
        tmax = 64'(trig_max);
        dly  = 64'(check_delay);
        return (nret >= 1) && (channel_idx < nret) &&
               (rc >= 64'd1) && (dly >= 64'd1) &&
               (tmax >= tmin) && (tmax < cmax) &&
               (rc - 64'd1 <= cmax) && (dly - 64'd1 <= cmax);
    endfunction

endpackage

// File: rtl/rvfi_check_scheduler_counter.sv
// Loadable down-counter with zero flag; stops at zero. Used for the reset
// window and the trig-to-check delay.
module rvfi_sched_counter #(
    parameter int unsigned     W         = 16,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/rvfi_check_scheduler.sv
// Sequences reset/trig/check for one RVFI formal checker instance.
// Optional `RVFI_SCHED_ABORT_EN adds the sticky 'aborted' output and ABORT state.
module rvfi_check_scheduler
    import rvfi_sched_pkg::*;
#(
    parameter int unsigned NRET         = DEF_NRET,
    parameter int unsigned CHANNEL_IDX  = DEF_CHANNEL_IDX,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned TRIG_MIN     = DEF_TRIG_MIN,
    parameter int unsigned TRIG_MAX     = DEF_TRIG_MAX,
    parameter int unsigned CHECK_DELAY  = DEF_CHECK_DELAY,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NRET-1:0]  rvfi_valid,
    input  logic [NRET-1:0]  rvfi_halt,
    output logic             chk_reset,
    output logic             trig,
    output logic             check,
    output logic             done,
    output logic [CNT_W-1:0] cycle
`ifdef RVFI_SCHED_ABORT_EN
    ,
    output logic             aborted
`endif
);

    if (!sched_params_ok(NRET, CHANNEL_IDX, RESET_CYCLES, TRIG_MIN, TRIG_MAX,
                         CHECK_DELAY, CNT_W)) begin : g_bad_params
        $error("rvfi_check_scheduler: invalid parameter combination");
    end

    // Counters load N-1 and fire on zero, giving exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD   = CNT_W'(CHECK_DELAY - 1);
    localparam logic [CNT_W-1:0] TRIG_MIN_V = CNT_W'(TRIG_MIN);
`ifdef RVFI_SCHED_ABORT_EN
    localparam logic [CNT_W-1:0] TRIG_MAX_V = CNT_W'(TRIG_MAX);
`endif

    sched_state_e     state_q, state_d;
    logic             chk_reset_q, chk_reset_d;
    logic             trig_q, trig_d;
    logic             check_q, check_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] cycle_sat;
    logic             qual_evt;
    logic             rst_zero;
    logic             dly_zero;
`ifdef RVFI_SCHED_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    assign qual_evt  = rvfi_valid[CHANNEL_IDX] && !rvfi_halt[CHANNEL_IDX];
    assign cycle_sat = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

    rvfi_sched_counter #(
        .W         (CNT_W),
        .RESET_VAL (RST_LOAD)
    ) u_rst_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .dec      (state_q == RST),
        .zero     (rst_zero)
    );

    rvfi_sched_counter #(
        .W         (CNT_W),
        .RESET_VAL ('0)
    ) u_dly_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (trig_d),
        .load_val (DLY_LOAD),
        .dec      (state_q == WAIT),
        .zero     (dly_zero)
    );

    // Decisions use the cycle value visible this clock; the resulting pulse
    // appears on the registered outputs in the following cycle.
    always_comb begin
        state_d     = state_q;
        chk_reset_d = 1'b0;
        trig_d      = 1'b0;
        check_d     = 1'b0;
        done_d      = done_q;
        cycle_d     = cycle_q;
`ifdef RVFI_SCHED_ABORT_EN
        aborted_d   = aborted_q;
`endif
        case (state_q)
            RST: begin
                chk_reset_d = 1'b1;
                cycle_d     = '0;
                if (rst_zero) begin
                    state_d     = ARM;
                    chk_reset_d = 1'b0;
                end
            end
            ARM: begin
                cycle_d = cycle_sat;
                if ((cycle_q >= TRIG_MIN_V) && qual_evt) begin
                    trig_d  = 1'b1;
                    state_d = WAIT;
                end
`ifdef RVFI_SCHED_ABORT_EN
                else if (cycle_q > TRIG_MAX_V) begin
                    state_d   = ABORT;
                    aborted_d = 1'b1;
                end
`endif
            end
            WAIT: begin
                cycle_d = cycle_sat;
                if (dly_zero) begin
                    check_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cycle_d = cycle_sat;
                done_d  = 1'b1;
            end
            ABORT: begin
                cycle_d = cycle_sat;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RST;
            chk_reset_q <= 1'b1;
            trig_q      <= 1'b0;
            check_q     <= 1'b0;
            done_q      <= 1'b0;
            cycle_q     <= '0;
`ifdef RVFI_SCHED_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            chk_reset_q <= chk_reset_d;
            trig_q      <= trig_d;
            check_q     <= check_d;
            done_q      <= done_d;
            cycle_q     <= cycle_d;
`ifdef RVFI_SCHED_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    assign chk_reset = chk_reset_q;
    assign trig      = trig_q;
    assign check     = check_q;
    assign done      = done_q;
    assign cycle     = cycle_q;
`ifdef RVFI_SCHED_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_rvfi_check_scheduler.sv
// Bench for rvfi_check_scheduler: a vector table, hand-written corner sequences
// and random stimulus against a timeline reference model, on two configurations.
module tb_rvfi_check_scheduler;

`ifdef RVFI_SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] valid;
    logic [1:0] halt;
    logic       b_valid;
    logic       b_halt;

    logic        a_chk_reset, a_trig, a_check, a_done;
    logic [15:0] a_cycle;
    logic        b_chk_reset, b_trig, b_check, b_done;
    logic [4:0]  b_cycle;
`ifdef RVFI_SCHED_ABORT_EN
    logic        a_aborted, b_aborted;
`endif

    always #5 clock = ~clock;

    rvfi_check_scheduler #(
        .NRET(2), .CHANNEL_IDX(0), .RESET_CYCLES(3), .TRIG_MIN(4),
        .TRIG_MAX(20), .CHECK_DELAY(10), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .rvfi_valid(valid), .rvfi_halt(halt),
        .chk_reset(a_chk_reset), .trig(a_trig), .check(a_check),
        .done(a_done), .cycle(a_cycle)
`ifdef RVFI_SCHED_ABORT_EN
        , .aborted(a_aborted)
`endif
    );

    rvfi_check_scheduler #(
        .NRET(1), .CHANNEL_IDX(0), .RESET_CYCLES(1), .TRIG_MIN(2),
        .TRIG_MAX(6), .CHECK_DELAY(1), .CNT_W(5)
    ) dut_b (
        .clock(clock), .reset(reset), .rvfi_valid(b_valid), .rvfi_halt(b_halt),
        .chk_reset(b_chk_reset), .trig(b_trig), .check(b_check),
        .done(b_done), .cycle(b_cycle)
`ifdef RVFI_SCHED_ABORT_EN
        , .aborted(b_aborted)
`endif
    );

    // Timeline model: k counts clock edges since the last reset edge; every
    // output is a pure function of k and the edges where trig/abort were decided.
    typedef struct {
        longint rc, tmin, tmax, dly, cmax;
        longint k, trig_k, abort_k;
        bit     live;
    } model_t;

    model_t ma = '{rc:3, tmin:4, tmax:20, dly:10, cmax:65535, k:0, trig_k:-1, abort_k:-1, live:0};
    model_t mb = '{rc:1, tmin:2, tmax:6,  dly:1,  cmax:31,    k:0, trig_k:-1, abort_k:-1, live:0};

    int errors = 0;
    int checks = 0;

    function automatic longint m_cyc(input model_t m, input longint k);
        if (k <= m.rc) return 0;
        return (k - m.rc > m.cmax) ? m.cmax : k - m.rc;
    endfunction

    function automatic void m_step(inout model_t m, input bit r, input bit ev);
        if (r) begin
            m.k = 0; m.trig_k = -1; m.abort_k = -1; m.live = 1'b1;
            return;
        end
        if (m.k >= m.rc && m.trig_k < 0 && m.abort_k < 0) begin
            if (ev && m_cyc(m, m.k) >= m.tmin) m.trig_k = m.k;
            else if (ABORT_EN && m_cyc(m, m.k) > m.tmax) m.abort_k = m.k;
        end
        m.k = m.k + 1;
    endfunction

    function automatic bit e_chk(input model_t m);   return m.k < m.rc; endfunction
    function automatic bit e_trig(input model_t m);  return m.trig_k >= 0 && m.k == m.trig_k + 1; endfunction
    function automatic bit e_check(input model_t m); return m.trig_k >= 0 && m.k == m.trig_k + 1 + m.dly; endfunction
    function automatic bit e_done(input model_t m);  return m.trig_k >= 0 && m.k >= m.trig_k + 2 + m.dly; endfunction
`ifdef RVFI_SCHED_ABORT_EN
    function automatic bit e_ab(input model_t m);    return m.abort_k >= 0 && m.k >= m.abort_k + 1; endfunction
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (ma.live) begin
            chk("a_chk_reset", a_chk_reset, e_chk(ma));
            chk("a_trig", a_trig, e_trig(ma));
            chk("a_check", a_check, e_check(ma));
            chk("a_done", a_done, e_done(ma));
            chk("a_cycle", a_cycle, m_cyc(ma, ma.k));
`ifdef RVFI_SCHED_ABORT_EN
            chk("a_aborted", a_aborted, e_ab(ma));
`endif
        end
        if (mb.live) begin
            chk("b_chk_reset", b_chk_reset, e_chk(mb));
            chk("b_trig", b_trig, e_trig(mb));
            chk("b_check", b_check, e_check(mb));
            chk("b_done", b_done, e_done(mb));
            chk("b_cycle", b_cycle, m_cyc(mb, mb.k));
`ifdef RVFI_SCHED_ABORT_EN
            chk("b_aborted", b_aborted, e_ab(mb));
`endif
        end
    endtask

    // One clock: drive inputs, sample 1ns after the edge, advance models, compare.
    task automatic tick(input bit r, input logic [1:0] v, input logic [1:0] h);
        reset = r; valid = v; halt = h; b_valid = v[0]; b_halt = h[0];
        @(posedge clock);
        #1;
        m_step(ma, r, v[0] & ~h[0]);
        m_step(mb, r, v[0] & ~h[0]);
        compare_all();
    endtask

    typedef struct {
        bit rst; bit ev;
        bit chk_reset; bit trig; bit check; bit done; int unsigned cyc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int ntrig, nchk, first_ab, n;
        longint c;
        logic [1:0] v, h;
        bit r, saw;
        int unsigned thr;

        reset = 1'b1; valid = '0; halt = '0; b_valid = 1'b0; b_halt = 1'b0;

        // Continuous event on dut_a: 3-cycle reset window, event first
        // eligible at cycle 4, trig visible the next cycle, check 10 after.
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 2};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 3};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 4};
        tbl[8]  = '{0, 1, 0, 1, 0, 0, 5};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 6};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 7};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 8};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 9};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 10};
        tbl[14] = '{0, 1, 0, 0, 0, 0, 11};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 12};
        tbl[16] = '{0, 1, 0, 0, 0, 0, 13};
        tbl[17] = '{0, 1, 0, 0, 0, 0, 14};
        tbl[18] = '{0, 1, 0, 0, 1, 0, 15};
        tbl[19] = '{0, 1, 0, 0, 0, 1, 16};
        tbl[20] = '{0, 1, 0, 0, 0, 1, 17};

        for (int i = 0; i < 21; i++) begin
            tick(tbl[i].rst, {1'b0, tbl[i].ev}, 2'b00);
            chk("t1_chk_reset", a_chk_reset, tbl[i].chk_reset);
            chk("t1_trig", a_trig, tbl[i].trig);
            chk("t1_check", a_check, tbl[i].check);
            chk("t1_done", a_done, tbl[i].done);
            chk("t1_cycle", a_cycle, tbl[i].cyc);
        end

        // Events only at cycles 2 and 7.
        tick(1'b1, 2'b00, 2'b00);
        ntrig = 0;
        for (int i = 0; i < 30; i++) begin
            c = m_cyc(ma, ma.k);
            tick(1'b0, {1'b0, (ma.k >= ma.rc) && (c == 2 || c == 7)}, 2'b00);
            if (a_trig) begin ntrig++; chk("t2_trig_cycle", a_cycle, 8); end
            if (a_check) chk("t2_check_cycle", a_cycle, 18);
        end
        chk("t2_trig_count", ntrig, 1);

        // Events on channel 1 only.
        tick(1'b1, 2'b00, 2'b00);
        ntrig = 0; first_ab = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 2'b10, 2'b00);
            ntrig += int'(a_trig);
`ifdef RVFI_SCHED_ABORT_EN
            if (a_aborted === 1'b1 && first_ab < 0) first_ab = int'(a_cycle);
`endif
        end
        chk("t3_trig_count", ntrig, 0);
        chk("t3_done", a_done, 0);
        chk("t3_cycle", a_cycle, 27);
`ifdef RVFI_SCHED_ABORT_EN
        chk("t3_abort_cycle", first_ab, 22);
`else
        chk("t3_chk_reset", a_chk_reset, 0);
`endif

        // Halted retirement at cycle 5, clean one at cycle 6.
        tick(1'b1, 2'b00, 2'b00);
        ntrig = 0;
        for (int i = 0; i < 20; i++) begin
            c = m_cyc(ma, ma.k);
            v = '0; h = '0;
            if (ma.k >= ma.rc && c == 5) begin v = 2'b01; h = 2'b01; end
            if (ma.k >= ma.rc && c == 6) v = 2'b01;
            tick(1'b0, v, h);
            if (a_trig) begin ntrig++; chk("t4_trig_cycle", a_cycle, 7); end
        end
        chk("t4_trig_count", ntrig, 1);

        // Reset three cycles after trig, during the delay.
        tick(1'b1, 2'b01, 2'b00);
        saw = 1'b0; nchk = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 2'b01, 2'b00);
            if (a_trig) begin saw = 1'b1; break; end
        end
        chk("t5_trig_seen", saw, 1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 2'b01, 2'b00);
            nchk += int'(a_check);
        end
        tick(1'b1, 2'b01, 2'b00);
        chk("t5_rst_chk_reset", a_chk_reset, 1);
        chk("t5_rst_done", a_done, 0);
        chk("t5_rst_check", a_check, 0);
        chk("t5_rst_trig", a_trig, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 2'b01, 2'b00);
            n++;
            nchk += int'(a_check);
            if (a_trig) break;
        end
        chk("t5_retrig_ticks", n, 8);
        chk("t5_no_check", nchk, 0);

        // Run to DONE, then 1000 cycles of continuous events.
        tick(1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 20; i++) tick(1'b0, 2'b11, 2'b00);
        ntrig = 0; nchk = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0, 2'b11, 2'b00);
            ntrig += int'(a_trig) + int'(b_trig);
            nchk  += int'(a_check) + int'(b_check);
        end
        chk("t6_trig_after_done", ntrig, 0);
        chk("t6_check_after_done", nchk, 0);
        chk("t6_a_done", a_done, 1);
        chk("t6_b_done", b_done, 1);
        chk("t6_a_cycle", a_cycle, 1017);
        chk("t6_b_cycle_sat", b_cycle, 31);

        // Random traffic with occasional resets and varying event density.
        thr = 8;
        for (int i = 0; i < 3000; i++) begin
            r = (i == 0) || ($urandom_range(0, 299) == 0);
            if (r) begin
                case ($urandom_range(0, 3))
                    0: thr = 1;
                    1: thr = 8;
                    2: thr = 32;
                    default: thr = 64;
                endcase
            end
            v[0] = ($urandom_range(0, 63) < thr);
            v[1] = 1'($urandom_range(0, 1));
            h = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            tick(r, v, h);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
